regc_bus_reader: RTL and testbench
==================================

// Module: regc_bus_reader
// PURPOSE
//  Read-side unloader for the 32-bit result register C. It snapshots the register's output on request.
//  The snapshot is then sent as BUS_W-wide beats onto the CPU's 16-bit internal data bus, using a valid/ready handshake.
//  It sits between the result register and the bus/writeback path; the register itself is unchanged.
// PARAMETERS
//  DATA_W    32  width of register C data (must be an integer multiple of BUS_W)
//  BUS_W     16  width of each bus beat
//  LO_FIRST  1   1: least-significant beat first; 0: most-significant beat first
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       read request; honoured only in IDLE
//  regc_data  in   DATA_W  register C output (dataCout side)
//  bus_ready  in   1       downstream accepts the current beat
//  bus_valid  out  1       current beat valid
//  bus_data   out  BUS_W   current beat
//  bus_last   out  1       high with the final beat
//  busy       out  1       high from start acceptance until done
//  done       out  1       one-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset (rst=1 at rising edge): state=IDLE; bus_valid, bus_last, busy, done = 0; bus_data=0; beat count=0.
//  - Reset mid-transfer aborts immediately: the snapshot is discarded and no done pulse is generated.
//  - Beats: BEATS = DATA_W/BUS_W (2 at default).
//  - States:
//    - IDLE: start=1 at an edge -> snapshot<=regc_data, count<=0, go SEND. Valid appears in the cycle after the edge (latency 1).
//    - SEND: bus_valid=1, busy=1.
//      - Beat index i = count (LO_FIRST=1) or BEATS-1-count (LO_FIRST=0); bus_data = snapshot[i*BUS_W +: BUS_W].
//      - Handshake = bus_valid & bus_ready at an edge.
//      - On handshake with count<BEATS-1: count++ and stay in SEND.
//      - On handshake with count==BEATS-1: go DONE.
//      - Without a handshake, bus_data and bus_last hold stable. No timeout.
//    - DONE: bus_valid=0, busy=0, done=1 for exactly one cycle -> IDLE.
//  - bus_last = (state==SEND) & (count==BEATS-1).
//  - start is ignored in SEND and DONE; it is not queued.
//    Minimum spacing between two transfers is therefore BEATS+2 cycles with ready held high.
//  - Changes on regc_data after the snapshot edge have no effect on the beats in flight.
//  - bus_ready while bus_valid=0 is ignored.
//  - Outputs are registered or decoded from registered state only; there is no combinational path from bus_ready to bus_valid.
// CONFIGURATION
//  REGC_RD_PARITY_EN defined:
//    - Adds output port bus_par (1 bit) = even parity (XOR reduce) of the current bus_data.
//    - bus_par is valid whenever bus_valid=1 and is 0 in reset/IDLE/DONE.
//  REGC_RD_PARITY_EN undefined:
//    - No bus_par port and no parity logic; all other behaviour is identical.
// STRUCTURE
//  - Package regc_pkg holds:
//    - the state encoding localparams ST_IDLE=2'd0, ST_SEND=2'd1, ST_DONE=2'd2;
//    - default widths REGC_DATA_W=32 and CPU_BUS_W=16;
//    - the function regc_beats(data_w, bus_w).
//  - One sub-module, regc_beat_sel: combinational beat mux (snapshot, index -> bus_data), plus bus_par under the macro.
//  - FSM, counter and snapshot register stay in the top.
// TESTING
//  1. Reset with regc_data=32'hDEADBEEF and start=1 during rst -> all outputs 0, no transfer; after rst releases, start accepted on the next edge.
//  2. LO_FIRST=1, regc_data=32'h00F430FE, start pulse, ready=1 ->
//     beats 16'h30FE then 16'h00F4 (last=1) on consecutive cycles; done pulse on the following cycle; busy high 2 cycles.
//  3. Stall: regc_data=32'h12340FE6, ready=0 for 4 cycles -> bus_data holds 16'h0FE6, valid stays 1; ready=1 -> 16'h1234, then done.
//  4. Snapshot isolation: after the start edge, change regc_data to 32'hFFFFFFFF and pulse start again during SEND ->
//     original beats delivered; second start ignored; no second done.
//  5. Reset mid-transfer: assert rst after the first handshake -> valid=0 next cycle, no done pulse; a new start then sends beat 0 fresh.
//  6. LO_FIRST=0 with REGC_RD_PARITY_EN, regc_data=32'h00070001 -> beats 16'h0007 (par=1) then 16'h0001 (par=1, last=1).

Source files
------------

// File: rtl/regc_pkg.sv
// rtl/regc_pkg.sv - shared state encoding, default widths and beat-count helper for the register C reader
package regc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int REGC_DATA_W = 32;
    localparam int CPU_BUS_W   = 16;

    // DATA_W is expected to be an exact multiple of BUS_W.
    function automatic int regc_beats(input int data_w, input int bus_w);
        return data_w / bus_w;
    endfunction

endpackage

// File: rtl/regc_beat_sel.sv
// rtl/regc_beat_sel.sv - combinational beat mux from snapshot and beat count; bus_par added under REGC_RD_PARITY_EN
module regc_beat_sel
    import regc_pkg::*;
#(
    parameter int DATA_W   = REGC_DATA_W,
    parameter int BUS_W    = CPU_BUS_W,
    parameter int LO_FIRST = 1,
    parameter int CNT_W    = 1
) (
    input  logic [DATA_W-1:0] snapshot,
    input  logic [CNT_W-1:0]  count,
    input  logic              active,
    output logic [BUS_W-1:0]  bus_data
`ifdef REGC_RD_PARITY_EN
    ,
    output logic              bus_par
`endif
);

    localparam int BEATS = regc_beats(DATA_W, BUS_W);

    logic [CNT_W-1:0] idx;

    // Outside SEND the beat is forced to zero, which also zeroes the parity.
    always_comb begin
        idx      = (LO_FIRST != 0) ? count : (CNT_W'(BEATS - 1) - count);
        bus_data = '0;
        if (active) begin
            for (int b = 0; b < BEATS; b++) begin
                if (idx == CNT_W'(b)) begin
                    bus_data = snapshot[b*BUS_W +: BUS_W];
                end
            end
        end
    end

`ifdef REGC_RD_PARITY_EN
    assign bus_par = ^bus_data;
`endif

endmodule

// File: rtl/regc_bus_reader.sv
// rtl/regc_bus_reader.sv - snapshots register C and streams it as bus beats; optional bus_par via REGC_RD_PARITY_EN
module regc_bus_reader
    import regc_pkg::*;
#(
    parameter int DATA_W   = REGC_DATA_W,
    parameter int BUS_W    = CPU_BUS_W,
    parameter int LO_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] regc_data,
    input  logic              bus_ready,
    output logic              bus_valid,
    output logic [BUS_W-1:0]  bus_data,
    output logic              bus_last,
    output logic              busy,
    output logic              done
`ifdef REGC_RD_PARITY_EN
    ,
    output logic              bus_par
`endif
);

    localparam int BEATS = regc_beats(DATA_W, BUS_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] snapshot;
    logic              handshake;

    assign handshake = bus_valid & bus_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            snapshot <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snapshot <= regc_data;
                        count    <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (count == LAST_CNT) begin
                            state <= ST_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All handshake outputs decode registered state only; bus_ready never reaches bus_valid.
    assign bus_valid = (state == ST_SEND);
    assign busy      = (state == ST_SEND);
    assign done      = (state == ST_DONE);
    assign bus_last  = (state == ST_SEND) && (count == LAST_CNT);

    regc_beat_sel #(
        .DATA_W   (DATA_W),
        .BUS_W    (BUS_W),
        .LO_FIRST (LO_FIRST),
        .CNT_W    (CNT_W)
    ) u_beat_sel (
        .snapshot (snapshot),
        .count    (count),
        .active   (state == ST_SEND),
        .bus_data (bus_data)
`ifdef REGC_RD_PARITY_EN
        ,
        .bus_par  (bus_par)
`endif
    );

endmodule

// File: tb/tb_regc_bus_reader.sv
// tb/tb_regc_bus_reader.sv - queue-model bench driving LO_FIRST=1 and LO_FIRST=0 readers side by side
module tb_regc_bus_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] regc_data = 32'h0;
    logic        bus_ready = 1'b0;

    logic        v0, l0, b0, d0, v1, l1, b1, d1;
    logic [15:0] q0d, q1d;
`ifdef REGC_RD_PARITY_EN
    logic        p0, p1;
`endif

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    regc_bus_reader #(.DATA_W(32), .BUS_W(16), .LO_FIRST(1)) dut_lo (
        .clk(clk), .rst(rst), .start(start), .regc_data(regc_data), .bus_ready(bus_ready),
        .bus_valid(v0), .bus_data(q0d), .bus_last(l0), .busy(b0), .done(d0)
`ifdef REGC_RD_PARITY_EN
        , .bus_par(p0)
`endif
    );

    regc_bus_reader #(.DATA_W(32), .BUS_W(16), .LO_FIRST(0)) dut_hi (
        .clk(clk), .rst(rst), .start(start), .regc_data(regc_data), .bus_ready(bus_ready),
        .bus_valid(v1), .bus_data(q1d), .bus_last(l1), .busy(b1), .done(d1)
`ifdef REGC_RD_PARITY_EN
        , .bus_par(p1)
`endif
    );

    // Model: a transfer is just a list of beats still owed, plus one pending done cycle.
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    bit          mdone0 = 1'b0;
    bit          mdone1 = 1'b0;

    task automatic model_step(input bit lo_first, inout logic [15:0] q[$], inout bit mdone);
        bit idle;
        idle = (q.size() == 0) && !mdone;
        mdone = 1'b0;
        if (rst) begin
            q.delete();
        end else if (q.size() != 0) begin
            if (bus_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) mdone = 1'b1;
            end
        end else if (idle && start) begin
            for (int k = 0; k < 2; k++) begin
                if (lo_first) q.push_back(16'((regc_data >> (16 * k)) & 32'hFFFF));
                else          q.push_back(16'((regc_data >> (16 * (1 - k))) & 32'hFFFF));
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(1'b1, mq0, mdone0);
        model_step(1'b0, mq1, mdone1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_one(input string tag, input logic [15:0] q[$], input bit mdone,
                           input logic v, input logic [15:0] d, input logic l,
                           input logic b, input logic dn, input logic p);
        logic [15:0] ed;
        ed = (q.size() != 0) ? q[0] : 16'h0;
        chk({tag, ".valid"}, {31'b0, v}, {31'b0, q.size() != 0});
        chk({tag, ".data"}, {16'b0, d}, {16'b0, ed});
        chk({tag, ".last"}, {31'b0, l}, {31'b0, q.size() == 1});
        chk({tag, ".busy"}, {31'b0, b}, {31'b0, q.size() != 0});
        chk({tag, ".done"}, {31'b0, dn}, {31'b0, mdone});
`ifdef REGC_RD_PARITY_EN
        chk({tag, ".par"}, {31'b0, p}, {31'b0, ^ed});
`else
        if (p !== 1'b0) chk({tag, ".par_tie"}, {31'b0, p}, 32'h0);
`endif
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
`ifdef REGC_RD_PARITY_EN
            cmp_one("lo", mq0, mdone0, v0, q0d, l0, b0, d0, p0);
            cmp_one("hi", mq1, mdone1, v1, q1d, l1, b1, d1, p1);
`else
            cmp_one("lo", mq0, mdone0, v0, q0d, l0, b0, d0, 1'b0);
            cmp_one("hi", mq1, mdone1, v1, q1d, l1, b1, d1, 1'b0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] words[4];
        logic [15:0] rdy_pat;

        // 1: reset holds everything low even with start asserted
        rst = 1'b1; start = 1'b1; regc_data = 32'hDEADBEEF; bus_ready = 1'b0;
        step(); cmp_en = 1'b1;
        step(); step();
        chk("rst.valid", {31'b0, v0 | v1}, 32'h0);
        chk("rst.data", {q0d, q1d}, 32'h0);
        chk("rst.flags", {28'b0, l0 | l1, b0 | b1, d0 | d1, 1'b0}, 32'h0);
        rst = 1'b0;
        step();
        chk("t1.beat0_lo", {16'b0, q0d}, 32'h0000BEEF);
        chk("t1.beat0_hi", {16'b0, q1d}, 32'h0000DEAD);
        start = 1'b0; bus_ready = 1'b1;
        step();
        chk("t1.beat1_lo", {15'b0, l0, q0d}, 32'h0001DEAD);
        step();
        chk("t1.done", {30'b0, d0, d1}, 32'h3);
        step();

        // 2: back-to-back beats with ready high
        regc_data = 32'h00F430FE; start = 1'b1;
        step(); start = 1'b0;
        chk("t2.beat0", {14'b0, b0, l0, q0d}, 32'h000230FE);
        step();
        chk("t2.beat1", {14'b0, b0, l0, q0d}, 32'h000300F4);
        step();
        chk("t2.done", {30'b0, d0, b0}, 32'h2);
        step();

        // 3: stall holds the beat
        regc_data = 32'h12340FE6; start = 1'b1; bus_ready = 1'b0;
        step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3.hold", {15'b0, v0, q0d}, 32'h00010FE6);
        end
        bus_ready = 1'b1;
        step();
        chk("t3.beat1", {15'b0, l0, q0d}, 32'h00011234);
        step();
        chk("t3.done", {31'b0, d0}, 32'h1);
        step();

        // 4: snapshot isolation and ignored starts
        regc_data = 32'hAAAA5555; start = 1'b1; bus_ready = 1'b0;
        step();
        regc_data = 32'hFFFFFFFF;
        step();
        chk("t4.hold", {16'b0, q0d}, 32'h00005555);
        start = 1'b0; bus_ready = 1'b1;
        step();
        chk("t4.beat1", {16'b0, q0d}, 32'h0000AAAA);
        start = 1'b1;
        step();
        chk("t4.done", {31'b0, d0}, 32'h1);
        start = 1'b0;
        step();
        chk("t4.no_restart", {30'b0, v0, d0}, 32'h0);
        step();
        chk("t4.no_done2", {31'b0, d0}, 32'h0);

        // 5: reset mid-transfer aborts without done
        regc_data = 32'hCAFEF00D; start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("t5.beat1", {16'b0, q0d}, 32'h0000CAFE);
        rst = 1'b1;
        step();
        chk("t5.abort", {30'b0, v0, d0}, 32'h0);
        rst = 1'b0;
        step();
        chk("t5.no_done", {30'b0, v0, d0}, 32'h0);
        regc_data = 32'h13572468; start = 1'b1;
        step(); start = 1'b0;
        chk("t5.fresh", {16'b0, q0d}, 32'h00002468);
        step(); step(); step();

        // 6: most-significant-first order and parity
        regc_data = 32'h00070001; start = 1'b1;
        step(); start = 1'b0;
        chk("t6.beat0_hi", {16'b0, q1d}, 32'h00000007);
`ifdef REGC_RD_PARITY_EN
        chk("t6.par0", {31'b0, p1}, 32'h1);
`endif
        step();
        chk("t6.beat1_hi", {15'b0, l1, q1d}, 32'h00010001);
`ifdef REGC_RD_PARITY_EN
        chk("t6.par1", {31'b0, p1}, 32'h1);
`endif
        step(); step();

        // mixed ready pattern over several words, checked by the model alone
        words[0] = 32'h80000001; words[1] = 32'h0000FFFF; words[2] = 32'h5A5AA5A5; words[3] = 32'h00000000;
        rdy_pat = 16'b1011_0110_1101_0011;
        for (int w = 0; w < 4; w++) begin
            regc_data = words[w]; start = 1'b1;
            for (int c = 0; c < 8; c++) begin
                bus_ready = rdy_pat[(w * 3 + c) % 16];
                step();
                start = 1'b0;
                regc_data = ~regc_data;
            end
            bus_ready = 1'b1;
            step(); step(); step();
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
